// File: rtl/halflife_decay_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : halflife_pkg
// Purpose  : Mode and state encodings shared by the half-life decay timer.
// Revision : 1.0 - initial release
// ============================================================================
package halflife_pkg;

   typedef enum logic [1:0] {
      MODE_DECAY = 2'b00,
      MODE_DOWN  = 2'b01,
      MODE_UP    = 2'b10,
      MODE_HOLD  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage
`default_nettype wire

// File: rtl/halflife_decay_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : halflife_decay_timer_if
// Purpose  : Load/control/status bundle between the wrapper and the timer.
// Revision : 1.0 - initial release
// ============================================================================
interface halflife_decay_timer_if #(
   parameter int WIDTH  = 8,
   parameter int PER_W  = 8,
   parameter int HCNT_W = 4
);
   logic              load_val;
   logic [WIDTH-1:0]  value_in;
   logic              load_per;
   logic [PER_W-1:0]  period_in;
   logic [1:0]        mode;
   logic              start;
   logic              stop;
   logic [WIDTH-1:0]  value;
   logic [HCNT_W-1:0] halves;
   logic              tick;
   logic              running;
   logic              done;

   modport master (
      output load_val, value_in, load_per, period_in, mode, start, stop,
      input  value, halves, tick, running, done
   );

   modport slave (
      input  load_val, value_in, load_per, period_in, mode, start, stop,
      output value, halves, tick, running, done
   );
endinterface
`default_nettype wire

// File: rtl/halflife_decay_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : halflife_prescaler
// Purpose  : Period counter; tick marks the cycle where count equals period.
// Revision : 1.0 - initial release
// ============================================================================
module halflife_prescaler #(
   parameter int PER_W = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             en,
   input  wire logic             clr,
   input  wire logic [PER_W-1:0] period,
   output logic                  tick
);
   logic [PER_W-1:0] r_count;

   assign tick = en & (r_count == period);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= tick ? '0 : r_count + PER_W'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/halflife_decay_timer.sv
`default_nettype none
// ============================================================================
// Module   : halflife_decay_timer
// Purpose  : Periodic value updater (halve / down / up / hold) with done flag.
// Revision : 1.0 - initial release
// ============================================================================
module halflife_decay_timer
   import halflife_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               PER_W      = 8,
   parameter int               HCNT_W     = 4,
   parameter logic [PER_W-1:0] PERIOD_RST = PER_W'(15)
) (
   input wire logic                clk,
   input wire logic                rst,
   halflife_decay_timer_if.slave   bus
);
   localparam logic [WIDTH-1:0]  c_val_max  = '1;
   localparam logic [HCNT_W-1:0] c_half_max = '1;

   state_t            r_state;
   logic [WIDTH-1:0]  r_value;
   logic [HCNT_W-1:0] r_halves;
   logic [PER_W-1:0]  r_period;
   logic              r_running;
   logic              r_done;

   mode_t             w_mode;
   logic              w_load;
   logic              w_expire;
   logic              w_tick;
   logic              w_start;
   logic [WIDTH-1:0]  w_next_value;

   function automatic logic is_terminal(input mode_t m, input logic [WIDTH-1:0] v);
      case (m)
         MODE_DECAY, MODE_DOWN: is_terminal = (v == '0);
         MODE_UP:               is_terminal = (v == c_val_max);
         default:               is_terminal = 1'b0;
      endcase
   endfunction

   assign w_mode  = mode_t'(bus.mode);
   assign w_load  = bus.load_val | bus.load_per;
   assign w_start = (r_state != ST_RUN) & bus.start;
   // Any higher-priority event in the expiry cycle swallows the tick.
   assign w_tick  = w_expire & ~rst & ~w_load & ~bus.stop;

   halflife_prescaler #(.PER_W(PER_W)) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .en     (r_state == ST_RUN),
      .clr    (w_load | (r_state != ST_RUN)),
      .period (r_period),
      .tick   (w_expire)
   );

   always_comb begin
      w_next_value = r_value;
      case (w_mode)
         MODE_DECAY: w_next_value = r_value >> 1;
         MODE_DOWN:  w_next_value = (r_value == '0) ? r_value : r_value - WIDTH'(1);
         MODE_UP:    w_next_value = (r_value == c_val_max) ? r_value : r_value + WIDTH'(1);
         default:    w_next_value = r_value;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_value   <= '0;
         r_halves  <= '0;
         r_period  <= PERIOD_RST;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else if (w_load) begin
         if (bus.load_val) begin
            r_value  <= bus.value_in;
            r_halves <= '0;
         end
         if (bus.load_per) begin
            r_period <= bus.period_in;
         end
      end else if ((r_state == ST_RUN) && bus.stop) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else if (w_start) begin
         if (is_terminal(w_mode, r_value)) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
         end else begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
         end
      end else if (w_tick) begin
         r_value <= w_next_value;
         if ((w_mode == MODE_DECAY) && (r_halves != c_half_max)) begin
            r_halves <= r_halves + HCNT_W'(1);
         end
         if (is_terminal(w_mode, w_next_value)) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
         end
      end
   end

   assign bus.value   = r_value;
   assign bus.halves  = r_halves;
   assign bus.tick    = w_tick;
   assign bus.running = r_running;
   assign bus.done    = r_done;
endmodule
`default_nettype wire
